// File: rtl/xgmii72_pkg.sv
// Shared XGMII 72-bit word constants and arbiter state encoding.
// Users of this package may be built with ARB_STAT_EN to enable per-source statistics.
package xgmii72_pkg;

    localparam logic [71:0] IDLE_WORD  = 72'hff_0707070707070707;
    localparam logic [71:0] TERM_WORD  = 72'hff_07070707070707fd;
    localparam logic [7:0]  START_CHAR = 8'hfb;
    localparam logic [7:0]  TERM_CHAR  = 8'hfd;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        FLUSH = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/xgmii72_word_class.sv
// Combinational classifier for one 72-bit XGMII word: start, end (terminate on any lane), idle.
// A word carrying both start and terminate characters reports only is_end.
module xgmii72_word_class
    import xgmii72_pkg::*;
(
    input  logic [71:0] word,
    output logic        is_start,
    output logic        is_end,
    output logic        is_idle
);

    logic [7:0] lane_term;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_term[gi] = word[64 + gi] && (word[8*gi +: 8] == TERM_CHAR);
        end
    endgenerate

    assign is_end   = |lane_term;
    assign is_start = word[64] && (word[7:0] == START_CHAR) && !is_end;
    assign is_idle  = (word == IDLE_WORD);

endmodule

// File: rtl/fifo72_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding one XGMII TX FIFO from two FWFT source FIFOs.
// Define ARB_STAT_EN to add frame_cnt0/frame_cnt1/trunc_cnt statistics outputs.
module fifo72_tx_arbiter
    import xgmii72_pkg::*;
#(
    parameter logic [3:0]  Gap      = 4'h2,
    parameter logic [11:0] MaxWords = 12'd200
) (
    input  logic        xgmii_tx_clk,
    input  logic        sys_rst_n,
    input  logic [71:0] dout0,
    input  logic        empty0,
    output logic        rd_en0,
    input  logic [71:0] dout1,
    input  logic        empty1,
    output logic        rd_en1,
    output logic [71:0] din,
    input  logic        full,
    output logic        wr_en,
    output logic        wr_clk
`ifdef ARB_STAT_EN
    ,
    output logic [31:0] frame_cnt0,
    output logic [31:0] frame_cnt1,
    output logic [15:0] trunc_cnt
`endif
);

    arb_state_t        state_reg, state_next;
    logic              grant_reg, grant_next;
    logic              last_grant_reg, last_grant_next;
    logic [3:0]        gap_cnt_reg, gap_cnt_next;
    logic [11:0]       word_cnt_reg, word_cnt_next;
    logic [71:0]       din_reg, din_next;
    logic              wr_en_reg, wr_en_next;

    logic [1:0][71:0]  head;
    logic [1:0]        empty_v, is_start_v, is_end_v, is_idle_v;
    logic [1:0]        start_v, discard_v, rd_en_v;
    logic              g_empty, g_end, g_pop, at_limit, term_wr, frame_end;
    logic [71:0]       g_word;

    assign head[0] = dout0;
    assign head[1] = dout1;
    assign empty_v = {empty1, empty0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            xgmii72_word_class u_class (
                .word     (head[gi]),
                .is_start (is_start_v[gi]),
                .is_end   (is_end_v[gi]),
                .is_idle  (is_idle_v[gi])
            );
            assign start_v[gi]   = !empty_v[gi] && is_start_v[gi];
            // Idle filler is the usual junk between frames; anything else not a START goes too.
            assign discard_v[gi] = !empty_v[gi] && (is_idle_v[gi] || !is_start_v[gi]);
        end
    endgenerate

    assign g_empty   = empty_v[grant_reg];
    assign g_end     = is_end_v[grant_reg];
    assign g_word    = head[grant_reg];
    assign at_limit  = (word_cnt_reg == MaxWords);
    assign g_pop     = !full && !g_empty &&
                       (((state_reg == XFER) && !at_limit) || (state_reg == FLUSH));
    assign term_wr   = (state_reg == XFER) && at_limit && !full;
    assign frame_end = g_pop && g_end;

    always_ff @(posedge xgmii_tx_clk) begin
        if (!sys_rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            gap_cnt_reg    <= 4'h0;
            word_cnt_reg   <= 12'h0;
            din_reg        <= 72'h0;
            wr_en_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            gap_cnt_reg    <= gap_cnt_next;
            word_cnt_reg   <= word_cnt_next;
            din_reg        <= din_next;
            wr_en_reg      <= wr_en_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        gap_cnt_next    = gap_cnt_reg;
        word_cnt_next   = word_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|start_v) begin
                    grant_next    = (&start_v) ? !last_grant_reg : start_v[1];
                    word_cnt_next = 12'h0;
                    state_next    = XFER;
                end
            end
            XFER: begin
                if (term_wr) begin
                    state_next = FLUSH;
                end else if (g_pop) begin
                    word_cnt_next = (word_cnt_reg == 12'hfff) ? word_cnt_reg : word_cnt_reg + 12'd1;
                end
            end
            GAP: begin
                if (gap_cnt_reg == 4'h0) begin
                    state_next = IDLE;
                end else if (!full) begin
                    gap_cnt_next = gap_cnt_reg - 4'd1;
                    if (gap_cnt_reg == 4'd1) begin
                        state_next = IDLE;
                    end
                end
            end
            default: ;
        endcase
        // Frame end is common to XFER and FLUSH (g_pop is only live in those states).
        if (frame_end) begin
            last_grant_next = grant_reg;
            gap_cnt_next    = Gap;
            state_next      = (Gap == 4'h0) ? IDLE : GAP;
        end
    end

    always_comb begin
        rd_en_v    = 2'b00;
        wr_en_next = 1'b0;
        din_next   = din_reg;
        case (state_reg)
            IDLE: begin
                if (!(|start_v) && !full) begin
                    rd_en_v = discard_v;
                end
            end
            XFER: begin
                if (g_pop) begin
                    rd_en_v[grant_reg] = 1'b1;
                    wr_en_next         = 1'b1;
                    din_next           = g_word;
                end else if (term_wr) begin
                    wr_en_next = 1'b1;
                    din_next   = TERM_WORD;
                end
            end
            FLUSH: begin
                if (g_pop) begin
                    rd_en_v[grant_reg] = 1'b1;
                end
            end
            GAP: begin
                if ((gap_cnt_reg != 4'h0) && !full) begin
                    wr_en_next = 1'b1;
                    din_next   = IDLE_WORD;
                end
            end
            default: ;
        endcase
    end

    assign rd_en0 = rd_en_v[0] && sys_rst_n;
    assign rd_en1 = rd_en_v[1] && sys_rst_n;
    assign din    = din_reg;
    assign wr_en  = wr_en_reg;
    assign wr_clk = xgmii_tx_clk;

`ifdef ARB_STAT_EN
    logic [31:0] frame_cnt0_reg, frame_cnt1_reg;
    logic [15:0] trunc_cnt_reg;

    // Only ENDs forwarded in XFER count; the END that closes a flushed frame does not.
    always_ff @(posedge xgmii_tx_clk) begin
        if (!sys_rst_n) begin
            frame_cnt0_reg <= 32'h0;
            frame_cnt1_reg <= 32'h0;
            trunc_cnt_reg  <= 16'h0;
        end else begin
            if (frame_end && (state_reg == XFER) && !grant_reg) frame_cnt0_reg <= frame_cnt0_reg + 32'd1;
            if (frame_end && (state_reg == XFER) && grant_reg)  frame_cnt1_reg <= frame_cnt1_reg + 32'd1;
            if (term_wr) trunc_cnt_reg <= trunc_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt0 = frame_cnt0_reg;
    assign frame_cnt1 = frame_cnt1_reg;
    assign trunc_cnt  = trunc_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo72_tx_arbiter.sv
// Directed bench for fifo72_tx_arbiter: queue-modelled FWFT sources, write log checked per test.
// Build with ARB_STAT_EN defined to also check the statistics counters.
module tb_fifo72_tx_arbiter;
    import xgmii72_pkg::*;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic [71:0] dout0, dout1;
    logic        empty0, empty1;
    logic        rd_en0, rd_en1;
    logic [71:0] din;
    logic        full;
    logic        wr_en, wr_clk;
`ifdef ARB_STAT_EN
    logic [31:0] frame_cnt0, frame_cnt1;
    logic [15:0] trunc_cnt;
    logic [31:0] fc0_before;
`endif

    logic [71:0] q0[$], q1[$], wlog[$], exp_q[$];
    logic        pend0 = 1'b0, pend1 = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    fifo72_tx_arbiter #(.Gap(4'h2), .MaxWords(12'd8)) dut (
        .xgmii_tx_clk (clk),
        .sys_rst_n    (sys_rst_n),
        .dout0        (dout0),
        .empty0       (empty0),
        .rd_en0       (rd_en0),
        .dout1        (dout1),
        .empty1       (empty1),
        .rd_en1       (rd_en1),
        .din          (din),
        .full         (full),
        .wr_en        (wr_en),
        .wr_clk       (wr_clk)
`ifdef ARB_STAT_EN
        ,
        .frame_cnt0   (frame_cnt0),
        .frame_cnt1   (frame_cnt1),
        .trunc_cnt    (trunc_cnt)
`endif
    );

    task automatic refresh();
        dout0  = (q0.size() != 0) ? q0[0] : 72'h0;
        empty0 = (q0.size() == 0);
        dout1  = (q1.size() != 0) ? q1[0] : 72'h0;
        empty1 = (q1.size() == 0);
    endtask

    // Source FIFO model: pop decision sampled mid-cycle, applied just after the edge.
    always @(negedge clk) begin
        #2;
        pend0 = rd_en0 && !empty0;
        pend1 = rd_en1 && !empty1;
        if (wr_en) wlog.push_back(din);
    end

    always @(posedge clk) begin
        #1;
        if (pend0 && q0.size() != 0) void'(q0.pop_front());
        if (pend1 && q1.size() != 0) void'(q1.pop_front());
        pend0 = 1'b0;
        pend1 = 1'b0;
        refresh();
    end

    function automatic logic [71:0] fw(input logic [7:0] tag, input int idx, input int n);
        logic [7:0] ib;
        ib = idx[7:0];
        if (idx == 0)          return {8'h01, 48'h555555555555, tag, 8'hfb};
        else if (idx == n - 1) return {8'hfc, 40'h0707070707, 8'hfd, tag, ib};
        else                   return {8'h00, 40'h0, tag, 8'h00, ib};
    endfunction

    task automatic push_frame(input int sel, input logic [7:0] tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) q0.push_back(fw(tag, i, n));
            else          q1.push_back(fw(tag, i, n));
        end
        refresh();
    endtask

    task automatic expect_frame(input logic [7:0] tag, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(fw(tag, i, n));
        exp_q.push_back(IDLE_WORD);
        exp_q.push_back(IDLE_WORD);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        full = 1'b0;
        refresh();
        repeat (2) @(negedge clk);
        q0.push_back(IDLE_WORD);
        refresh();
        #1;
        total++; if (rd_en0 !== 1'b0) begin bad++; $display("FAIL rst_rd_en0: got %b want 0", rd_en0); end
        total++; if (rd_en1 !== 1'b0) begin bad++; $display("FAIL rst_rd_en1: got %b want 0", rd_en1); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        total++; if (din !== 72'h0) begin bad++; $display("FAIL rst_din: got %h want 0", din); end
        total++; if (wr_clk !== clk) begin bad++; $display("FAIL rst_wr_clk: got %b want %b", wr_clk, clk); end
`ifdef ARB_STAT_EN
        total++; if ({frame_cnt0, frame_cnt1, trunc_cnt} !== 80'h0) begin bad++; $display("FAIL rst_stats: got %h/%h/%h want 0", frame_cnt0, frame_cnt1, trunc_cnt); end
`endif
        @(negedge clk);
        sys_rst_n = 1'b1;
        #1;
        total++; if (rd_en0 !== 1'b1) begin bad++; $display("FAIL rst_discard: rd_en0 got %b want 1", rd_en0); end
        @(negedge clk); #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_discard_nowrite: wr_en got %b want 0", wr_en); end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        wlog.delete();
        @(negedge clk);
        push_frame(0, 8'ha1, 4);
        #1;
        total++; if (rd_en0 !== 1'b0) begin bad++; $display("FAIL t1_grant_nopop: rd_en0 got %b want 0", rd_en0); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            total++; if (rd_en0 !== (k < 4)) begin bad++; $display("FAIL t1_pop%0d: rd_en0 got %b want %b", k, rd_en0, (k < 4)); end
            total++; if (wr_en !== (k > 0)) begin bad++; $display("FAIL t1_wr%0d: wr_en got %b want %b", k, wr_en, (k > 0)); end
            if (k > 0) begin
                total++;
                if (din !== fw(8'ha1, k - 1, 4)) begin bad++; $display("FAIL t1_din%0d: got %h want %h", k, din, fw(8'ha1, k - 1, 4)); end
                else $display("t1 write %0d din=%h", k - 1, din);
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            total++; if (wr_en !== 1'b1 || din !== IDLE_WORD) begin bad++; $display("FAIL t1_gap%0d: wr_en=%b din=%h want 1/%h", k, wr_en, din, IDLE_WORD); end
            else $display("t1 gap write %0d din=%h", k, din);
        end
        @(negedge clk); #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL t1_after_gap: wr_en got %b want 0", wr_en); end
    endtask

    task automatic test_both_start();
        sys_rst_n = 1'b0;
        @(negedge clk);
        sys_rst_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            wlog.delete();
            exp_q.delete();
            push_frame(0, 8'hb0 + 8'(r), 3);
            push_frame(1, 8'hc0 + 8'(r), 3);
            expect_frame(8'hb0 + 8'(r), 3);
            expect_frame(8'hc0 + 8'(r), 3);
            repeat (30) @(negedge clk);
            total++; if (wlog.size() != exp_q.size()) begin bad++; $display("FAIL t2_count%0d: got %0d writes want %0d", r, wlog.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
                total++;
                if (wlog[i] !== exp_q[i]) begin bad++; $display("FAIL t2_word%0d_%0d: got %h want %h", r, i, wlog[i], exp_q[i]); end
                else $display("t2 round %0d write %0d din=%h", r, i, wlog[i]);
            end
        end
    endtask

    task automatic test_full_hold();
        wlog.delete();
        exp_q.delete();
        @(negedge clk);
        push_frame(0, 8'hd3, 6);
        expect_frame(8'hd3, 6);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            full = 1'b1;
            #1;
            total++; if (rd_en0 !== 1'b0) begin bad++; $display("FAIL t3_hold_rd%0d: rd_en0 got %b want 0", k, rd_en0); end
            // The first hold cycle carries the write committed before full rose.
            if (k > 0) begin
                total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL t3_hold_wr%0d: wr_en got %b want 0", k, wr_en); end
            end
        end
        @(negedge clk);
        full = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (wlog.size() != exp_q.size()) begin bad++; $display("FAIL t3_count: got %0d writes want %0d", wlog.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            total++;
            if (wlog[i] !== exp_q[i]) begin bad++; $display("FAIL t3_word%0d: got %h want %h", i, wlog[i], exp_q[i]); end
            else $display("t3 write %0d din=%h", i, wlog[i]);
        end
    endtask

    task automatic test_discard();
        wlog.delete();
        exp_q.delete();
        @(negedge clk);
        q0.push_back(IDLE_WORD);
        q0.push_back(IDLE_WORD);
        q0.push_back({8'h00, 64'h1122334455667788});
        push_frame(0, 8'he4, 3);
        expect_frame(8'he4, 3);
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            total++; if (rd_en0 !== (k != 3)) begin bad++; $display("FAIL t4_pop%0d: rd_en0 got %b want %b", k, rd_en0, (k != 3)); end
            total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL t4_nowrite%0d: wr_en got %b want 0", k, wr_en); end
        end
        repeat (15) @(negedge clk);
        total++; if (wlog.size() != exp_q.size()) begin bad++; $display("FAIL t4_count: got %0d writes want %0d", wlog.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            total++;
            if (wlog[i] !== exp_q[i]) begin bad++; $display("FAIL t4_word%0d: got %h want %h", i, wlog[i], exp_q[i]); end
            else $display("t4 write %0d din=%h", i, wlog[i]);
        end
    endtask

    task automatic test_truncate();
        wlog.delete();
        exp_q.delete();
`ifdef ARB_STAT_EN
        fc0_before = frame_cnt0;
`endif
        @(negedge clk);
        push_frame(0, 8'hf5, 12);
        for (int i = 0; i < 8; i++) exp_q.push_back(fw(8'hf5, i, 12));
        exp_q.push_back(TERM_WORD);
        exp_q.push_back(IDLE_WORD);
        exp_q.push_back(IDLE_WORD);
        repeat (30) @(negedge clk);
        total++; if (q0.size() != 0) begin bad++; $display("FAIL t5_flushed: %0d words left want 0", q0.size()); end
        total++; if (wlog.size() != exp_q.size()) begin bad++; $display("FAIL t5_count: got %0d writes want %0d", wlog.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            total++;
            if (wlog[i] !== exp_q[i]) begin bad++; $display("FAIL t5_word%0d: got %h want %h", i, wlog[i], exp_q[i]); end
            else $display("t5 write %0d din=%h", i, wlog[i]);
        end
`ifdef ARB_STAT_EN
        total++; if (trunc_cnt !== 16'd1) begin bad++; $display("FAIL t5_trunc_cnt: got %0d want 1", trunc_cnt); end
        total++; if (frame_cnt0 !== fc0_before) begin bad++; $display("FAIL t5_frame_cnt0: got %0d want %0d", frame_cnt0, fc0_before); end
`endif
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        push_frame(0, 8'h96, 6);
        repeat (2) @(negedge clk);
        @(negedge clk);
        sys_rst_n = 1'b0;
        #1;
        total++; if (rd_en0 !== 1'b0) begin bad++; $display("FAIL t6_rst_rd: rd_en0 got %b want 0", rd_en0); end
        q0.delete();
        refresh();
        @(negedge clk);
        sys_rst_n = 1'b1;
        wlog.delete();
        exp_q.delete();
        #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL t6_wr_en: got %b want 0", wr_en); end
        total++; if (din !== 72'h0) begin bad++; $display("FAIL t6_din: got %h want 0", din); end
`ifdef ARB_STAT_EN
        total++; if (trunc_cnt !== 16'd0) begin bad++; $display("FAIL t6_trunc_rst: got %0d want 0", trunc_cnt); end
`endif
        push_frame(0, 8'h17, 3);
        push_frame(1, 8'h28, 3);
        expect_frame(8'h17, 3);
        expect_frame(8'h28, 3);
        repeat (30) @(negedge clk);
        total++; if (wlog.size() != exp_q.size()) begin bad++; $display("FAIL t6_count: got %0d writes want %0d", wlog.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            total++;
            if (wlog[i] !== exp_q[i]) begin bad++; $display("FAIL t6_word%0d: got %h want %h", i, wlog[i], exp_q[i]); end
            else $display("t6 write %0d din=%h", i, wlog[i]);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        full = 1'b0;
        refresh();
        test_reset();
        test_single_frame();
        test_both_start();
        test_full_hold();
        test_discard();
        test_truncate();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
